// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order buffer between branch resolution and ROB writeback.
// Resolved branch results are queued and written back over a valid/ready handshake.
// When a taken branch is written back, a fetch redirect is raised and held until
// acknowledged, after which the remaining (wrong-path) queued results are discarded.
// Optional build macro BRQ_STATS_EN adds resolved/redirect event counters.
module branch_resolve_queue #(
   parameter int DEPTH      = 4,
   parameter int TAG_WIDTH  = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [TAG_WIDTH-1:0]  br_target,
   input  logic                  br_cmp_res,
   input  logic [DATA_WIDTH-1:0] br_next_pc,
   output logic                  br_stall,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [TAG_WIDTH-1:0]  wb_tag,
   output logic                  wb_taken,
   output logic [DATA_WIDTH-1:0] wb_pc,
   output logic                  redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  redirect_ack,
   input  logic                  flush
`ifdef BRQ_STATS_EN
   ,
   output logic [31:0]           stat_resolved,
   output logic [31:0]           stat_redirects
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(DEPTH);
   localparam logic [TAG_WIDTH-1:0] NO_TAG   = '1;

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_REDIRECT = 1'b1;

   logic [TAG_WIDTH-1:0]  q_tag   [DEPTH];
   logic                  q_taken [DEPTH];
   logic [DATA_WIDTH-1:0] q_pc    [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [0:0]       state;

   logic empty;
   logic is_idle;
   logic br_in;
   logic pop;
   logic push;
   logic drop;

   assign empty    = (count == '0);
   assign is_idle  = (state == S_IDLE);
   assign br_in    = (br_target != NO_TAG);
   assign br_stall = (count == FULL_CNT);

   // Head entry is only offered to the ROB while no redirect is outstanding.
   assign wb_valid = !empty && is_idle;
   assign wb_tag   = empty ? NO_TAG : q_tag[head];
   assign wb_taken = empty ? 1'b0 : q_taken[head];
   assign wb_pc    = empty ? '0 : q_pc[head];

   // flush outranks every other queue operation; a pop frees a slot for a same-cycle push.
   assign pop  = wb_valid && wb_ready && !flush;
   assign push = br_in && is_idle && !flush && (!br_stall || pop);
   assign drop = br_in && is_idle && !flush && br_stall && !pop;

   // Pointer, occupancy, redirect FSM and redirect request registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         state          <= S_IDLE;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else if (flush) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         state          <= S_IDLE;
         redirect_valid <= 1'b0;
      end else if (state == S_REDIRECT) begin
         // Everything still queued is younger than the taken branch, so it is wrong-path.
         if (redirect_ack) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            state          <= S_IDLE;
            redirect_valid <= 1'b0;
         end
      end else begin
         if (push)
            tail <= tail + PTR_W'(1);
         if (pop)
            head <= head + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (pop && wb_taken) begin
            state          <= S_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= wb_pc;
         end
      end
   end

   // Entry storage; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         q_tag[tail]   <= br_target;
         q_taken[tail] <= br_cmp_res;
         q_pc[tail]    <= br_next_pc;
      end
   end

`ifdef BRQ_STATS_EN
   // Event counters; free-running modulo 2^32 and untouched by flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_resolved  <= '0;
         stat_redirects <= '0;
      end else begin
         if (pop)
            stat_resolved <= stat_resolved + 32'd1;
         if (pop && wb_taken)
            stat_redirects <= stat_redirects + 32'd1;
      end
   end
`endif

   // Upstream must honour br_stall: a result offered while full and not popping is lost.
   assert property (@(posedge clk) disable iff (rst) !drop);

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed testbench for branch_resolve_queue (DEPTH=4, TAG_WIDTH=5, DATA_WIDTH=32).
// Counter checks are compiled in when BRQ_STATS_EN is defined.
module tb_branch_resolve_queue;

   localparam int DEPTH      = 4;
   localparam int TAG_WIDTH  = 5;
   localparam int DATA_WIDTH = 32;
   localparam logic [TAG_WIDTH-1:0] NO_TAG = 5'h1F;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [TAG_WIDTH-1:0]  br_target;
   logic                  br_cmp_res;
   logic [DATA_WIDTH-1:0] br_next_pc;
   logic                  br_stall;
   logic                  wb_valid;
   logic                  wb_ready;
   logic [TAG_WIDTH-1:0]  wb_tag;
   logic                  wb_taken;
   logic [DATA_WIDTH-1:0] wb_pc;
   logic                  redirect_valid;
   logic [DATA_WIDTH-1:0] redirect_pc;
   logic                  redirect_ack;
   logic                  flush;
`ifdef BRQ_STATS_EN
   logic [31:0]           stat_resolved;
   logic [31:0]           stat_redirects;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   branch_resolve_queue #(
      .DEPTH      (DEPTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .br_target      (br_target),
      .br_cmp_res     (br_cmp_res),
      .br_next_pc     (br_next_pc),
      .br_stall       (br_stall),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_tag         (wb_tag),
      .wb_taken       (wb_taken),
      .wb_pc          (wb_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ack   (redirect_ack),
      .flush          (flush)
`ifdef BRQ_STATS_EN
      ,
      .stat_resolved  (stat_resolved),
      .stat_redirects (stat_redirects)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [TAG_WIDTH-1:0] t, input logic tk, input logic [DATA_WIDTH-1:0] pc);
      br_target  = t;
      br_cmp_res = tk;
      br_next_pc = pc;
   endtask

   task automatic idle_in();
      br_target  = NO_TAG;
      br_cmp_res = 1'b0;
      br_next_pc = '0;
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_stall"},  br_stall, 0);
      chk({pfx, "_wbv"},    wb_valid, 0);
      chk({pfx, "_rv"},     redirect_valid, 0);
      chk({pfx, "_wbtag"},  wb_tag, NO_TAG);
      chk({pfx, "_wbtk"},   wb_taken, 0);
      chk({pfx, "_wbpc"},   wb_pc, 0);
      chk({pfx, "_rpc"},    redirect_pc, 0);
      chk({pfx, "_count"},  dut.count, 0);
   endtask

   initial begin
      logic [TAG_WIDTH-1:0]  t;
      logic                  tk;
      logic [DATA_WIDTH-1:0] pc;

      rst          = 1'b1;
      wb_ready     = 1'b0;
      redirect_ack = 1'b0;
      flush        = 1'b0;
      idle_in();
      tick();
      tick();
      chk_reset_vals("rst0");
      rst = 1'b0;
      tick();

      // A: tags 1,2,3 not-taken, ROB always ready
      wb_ready = 1'b1;
      present(5'd1, 1'b0, 32'h10);
      tick();
      chk("A_v1", wb_valid, 1);
      chk("A_t1", wb_tag, 1);
      present(5'd2, 1'b0, 32'h20);
      tick();
      chk("A_t2", wb_tag, 2);
      chk("A_pc2", wb_pc, 32'h20);
      chk("A_rv2", redirect_valid, 0);
      present(5'd3, 1'b0, 32'h30);
      tick();
      chk("A_t3", wb_tag, 3);
      chk("A_rv3", redirect_valid, 0);
      idle_in();
      tick();
      chk("A_empty", wb_valid, 0);
      chk("A_tagE", wb_tag, NO_TAG);
      chk("A_rv4", redirect_valid, 0);

      // B: fill to DEPTH (wrapping the tail), then push+pop while full
      wb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         present(TAG_WIDTH'(10 + i), 1'b0, DATA_WIDTH'((10 + i) * 16));
         tick();
      end
      idle_in();
      chk("B_stall", br_stall, 1);
      chk("B_count", dut.count, 4);
      chk("B_head", wb_tag, 10);
      present(5'd7, 1'b0, 32'h70);
      wb_ready = 1'b1;
      tick();
      idle_in();
      chk("B_stall2", br_stall, 1);
      chk("B_count2", dut.count, 4);
      chk("B_head2", wb_tag, 11);
      tick();
      chk("B_h12", wb_tag, 12);
      tick();
      chk("B_h13", wb_tag, 13);
      tick();
      chk("B_h7", wb_tag, 7);
      chk("B_pc7", wb_pc, 32'h70);
      tick();
      chk("B_empty", wb_valid, 0);
      chk("B_nostall", br_stall, 0);

      // C: taken branch redirect, wrong-path discard
      wb_ready = 1'b0;
      present(5'd2, 1'b1, 32'h0000_0100);
      tick();
      chk("C_tk", wb_taken, 1);
      chk("C_pc", wb_pc, 32'h100);
      present(5'd3, 1'b0, 32'h200);
      tick();
      idle_in();
      chk("C_cnt2", dut.count, 2);
      wb_ready = 1'b1;
      tick();
      chk("C_rv", redirect_valid, 1);
      chk("C_rpc", redirect_pc, 32'h100);
      chk("C_wbv", wb_valid, 0);
      for (int i = 0; i < 3; i++) begin
         present(5'd9, 1'b0, 32'h900);
         tick();
         chk("C_hold_rv", redirect_valid, 1);
         chk("C_hold_rpc", redirect_pc, 32'h100);
         chk("C_hold_wbv", wb_valid, 0);
         chk("C_hold_cnt", dut.count, 1);
      end
      idle_in();
      redirect_ack = 1'b1;
      tick();
      redirect_ack = 1'b0;
      chk("C_ack_rv", redirect_valid, 0);
      chk("C_ack_cnt", dut.count, 0);
      chk("C_ack_wbv", wb_valid, 0);
      chk("C_ack_tag", wb_tag, NO_TAG);
      chk("C_ack_st", dut.state, 0);
      wb_ready = 1'b0;

      // D: asynchronous reset while in REDIRECT with two entries queued
      present(5'd4, 1'b1, 32'h400);
      tick();
      present(5'd5, 1'b0, 32'h500);
      tick();
      present(5'd6, 1'b0, 32'h600);
      tick();
      idle_in();
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk("D_rv", redirect_valid, 1);
      chk("D_cnt", dut.count, 2);
      chk("D_rpc", redirect_pc, 32'h400);
      #2 rst = 1'b1;
      #1;
      chk_reset_vals("D_async");
      rst = 1'b0;
      tick();

      // E: flush with three entries and a same-cycle result
      for (int i = 1; i <= 3; i++) begin
         present(TAG_WIDTH'(i), 1'b0, DATA_WIDTH'(i));
         tick();
      end
      chk("E_cnt3", dut.count, 3);
      present(5'd8, 1'b0, 32'h800);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle_in();
      chk("E_cnt0", dut.count, 0);
      chk("E_wbv0", wb_valid, 0);
      tick();
      chk("E_cnt_after", dut.count, 0);
      chk("E_wbv_after", wb_valid, 0);
      // redirect_ack in IDLE has no effect
      present(5'd4, 1'b0, 32'h44);
      redirect_ack = 1'b1;
      tick();
      redirect_ack = 1'b0;
      idle_in();
      chk("E_ackidle_cnt", dut.count, 1);
      chk("E_ackidle_tag", wb_tag, 4);
      chk("E_ackidle_rv", redirect_valid, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // F: ten pops, two of them taken and acknowledged
      for (int i = 0; i < 10; i++) begin
         t  = TAG_WIDTH'(i + 1);
         tk = (i == 3) || (i == 7);
         pc = DATA_WIDTH'(32'h1000 + i * 4);
         present(t, tk, pc);
         tick();
         idle_in();
         chk("F_head", wb_tag, t);
         wb_ready = 1'b1;
         tick();
         wb_ready = 1'b0;
         if (tk) begin
            chk("F_rv", redirect_valid, 1);
            chk("F_rpc", redirect_pc, pc);
            redirect_ack = 1'b1;
            tick();
            redirect_ack = 1'b0;
         end
         chk("F_rv_clear", redirect_valid, 0);
         chk("F_empty", wb_valid, 0);
      end
`ifdef BRQ_STATS_EN
      chk("F_stat_res", stat_resolved, 10);
      chk("F_stat_red", stat_redirects, 2);
      force dut.stat_resolved = 32'hFFFF_FFFF;
      #1;
      release dut.stat_resolved;
      present(5'd12, 1'b0, 32'h12);
      tick();
      idle_in();
      chk("F_stat_pre", stat_resolved, 32'hFFFF_FFFF);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk("F_stat_wrap", stat_resolved, 0);
      chk("F_stat_red2", stat_redirects, 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
